// File: rtl/guess_entry_ctrl.sv
// guess_entry_ctrl: builds a 5-letter guess from debounced button pulses,
// offers it to the word checker over valid/ready, counts guesses, locks out.
//
// Ports:
//   logicclk     system clock, rising edge
//   clr          asynchronous active-high reset
//   btn_up/down  1-cycle pulses: change the letter under the cursor
//   btn_left/right 1-cycle pulses: move the cursor (saturating 0..4)
//   btn_enter    1-cycle pulse: submit the guess
//   game_won     checker reports a win (honoured only while editing)
//   guess_ready  checker accepts the offered guess this cycle
//   guess_word   slot 0 in [4:0] .. slot 4 in [24:20]
//   cursor       active slot 0..4
//   guess_valid  guess_word is frozen and offered to the checker
//   guess_count  accepted submissions so far
//   locked       input locked out (win or guess limit)
//
// Optional feature macro RETAIN_GUESS_EN: when defined, an accepted guess
// stays in the buffer as the starting point for the next one; otherwise
// the buffer is cleared to all 'A'.

module guess_entry_ctrl #(
    parameter int MAX_GUESSES = 6,
    parameter int LETTER_MAX  = 25
) (
    input  logic        logicclk,
    input  logic        clr,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_enter,
    input  logic        game_won,
    input  logic        guess_ready,
    output logic [24:0] guess_word,
    output logic [2:0]  cursor,
    output logic        guess_valid,
    output logic [2:0]  guess_count,
    output logic        locked
);

    typedef enum logic [1:0] {
        EDIT   = 2'd0,
        SUBMIT = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [4:0] LMAX     = 5'(LETTER_MAX);
    localparam logic [2:0] MAXG     = 3'(MAX_GUESSES);
    localparam logic [2:0] CUR_LAST = 3'd4;

    state_t     state_q, state_d;
    logic [4:0] let_q [5];
    logic [4:0] let_d [5];
    logic [2:0] cursor_q, cursor_d;
    logic [2:0] count_q, count_d;

    logic [4:0] cur_let;
    logic [4:0] new_let;
    logic       horiz, vert;
    logic       act_won, act_enter, act_horiz, act_vert;
    logic [2:0] count_inc;

    // One-hot action decode: win beats enter beats horizontal beats
    // vertical. Opposing pulses still claim their priority slot, so
    // left+right swallows up/down in the same cycle.
    assign horiz     = btn_left | btn_right;
    assign vert      = btn_up ^ btn_down;
    assign act_won   = game_won;
    assign act_enter = ~game_won & btn_enter;
    assign act_horiz = ~game_won & ~btn_enter & horiz;
    assign act_vert  = ~game_won & ~btn_enter & ~horiz & vert;

    assign count_inc = count_q + 3'd1;

    always_comb begin
        cur_let = let_q[0];
        for (int i = 0; i < 5; i++) begin
            if (cursor_q == 3'(i)) begin
                cur_let = let_q[i];
            end
        end
    end

    always_comb begin
        new_let = cur_let;
        if (btn_up) begin
            new_let = (cur_let == LMAX) ? 5'd0 : cur_let + 5'd1;
        end else begin
            new_let = (cur_let == 5'd0) ? LMAX : cur_let - 5'd1;
        end
    end

    always_comb begin
        state_d  = state_q;
        cursor_d = cursor_q;
        count_d  = count_q;
        for (int i = 0; i < 5; i++) begin
            let_d[i] = let_q[i];
        end

        unique case (state_q)
            EDIT: begin
                unique case (1'b1)
                    act_won:   state_d = LOCKED;
                    act_enter: state_d = SUBMIT;
                    act_horiz: begin
                        if (btn_left && !btn_right && cursor_q != 3'd0) begin
                            cursor_d = cursor_q - 3'd1;
                        end
                        if (btn_right && !btn_left && cursor_q != CUR_LAST) begin
                            cursor_d = cursor_q + 3'd1;
                        end
                    end
                    act_vert: begin
                        for (int i = 0; i < 5; i++) begin
                            if (cursor_q == 3'(i)) begin
                                let_d[i] = new_let;
                            end
                        end
                    end
                    default: ;
                endcase
            end

            // guess_valid is high for the whole of SUBMIT, so ready alone
            // completes the handshake here.
            SUBMIT: begin
                if (guess_ready) begin
                    count_d  = count_inc;
                    cursor_d = 3'd0;
`ifndef RETAIN_GUESS_EN
                    for (int i = 0; i < 5; i++) begin
                        let_d[i] = 5'd0;
                    end
`endif
                    state_d = (count_inc == MAXG) ? LOCKED : EDIT;
                end
            end

            LOCKED: ;

            default: state_d = EDIT;
        endcase
    end

    always_ff @(posedge logicclk or posedge clr) begin
        if (clr) begin
            state_q  <= EDIT;
            cursor_q <= 3'd0;
            count_q  <= 3'd0;
            for (int i = 0; i < 5; i++) begin
                let_q[i] <= 5'd0;
            end
        end else begin
            state_q  <= state_d;
            cursor_q <= cursor_d;
            count_q  <= count_d;
            for (int i = 0; i < 5; i++) begin
                let_q[i] <= let_d[i];
            end
        end
    end

    // Outputs decode straight from flops; guess_valid falls with clr
    // because the state register resets asynchronously.
    assign guess_word  = {let_q[4], let_q[3], let_q[2], let_q[1], let_q[0]};
    assign cursor      = cursor_q;
    assign guess_count = count_q;
    assign guess_valid = (state_q == SUBMIT);
    assign locked      = (state_q == LOCKED);

endmodule

// File: tb/tb_guess_entry_ctrl.sv
// tb_guess_entry_ctrl: directed scenarios plus randomized pulses checked
// against a behavioural model of the guess entry rules.

module tb_guess_entry_ctrl;

    localparam int MAXG = 6;
    localparam int LMAX = 25;

    logic        logicclk = 1'b0;
    logic        clr = 1'b1;
    logic        btn_up = 0, btn_down = 0, btn_left = 0, btn_right = 0;
    logic        btn_enter = 0, game_won = 0, guess_ready = 0;
    logic [24:0] guess_word;
    logic [2:0]  cursor;
    logic        guess_valid;
    logic [2:0]  guess_count;
    logic        locked;

    int tests = 0;
    int fails = 0;

    // model: 0 editing, 1 offering guess, 2 locked out
    int m_let [5];
    int m_cur, m_cnt, m_mode;

    guess_entry_ctrl #(.MAX_GUESSES(MAXG), .LETTER_MAX(LMAX)) dut (
        .logicclk(logicclk), .clr(clr),
        .btn_up(btn_up), .btn_down(btn_down),
        .btn_left(btn_left), .btn_right(btn_right),
        .btn_enter(btn_enter), .game_won(game_won),
        .guess_ready(guess_ready),
        .guess_word(guess_word), .cursor(cursor),
        .guess_valid(guess_valid), .guess_count(guess_count),
        .locked(locked)
    );

    always #5 logicclk = ~logicclk;

    function automatic logic [24:0] m_word();
        logic [24:0] w = '0;
        for (int i = 0; i < 5; i++) w = w | (25'(m_let[i]) << (5 * i));
        return w;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 5; i++) m_let[i] = 0;
        m_cur = 0; m_cnt = 0; m_mode = 0;
    endtask

    task automatic m_step(input logic u, d, l, r, e, w, rd);
        if (m_mode == 0) begin
            if (w) m_mode = 2;
            else if (e) m_mode = 1;
            else if (l || r) begin
                if (l && !r && m_cur > 0) m_cur--;
                if (r && !l && m_cur < 4) m_cur++;
            end else if (u && !d) m_let[m_cur] = (m_let[m_cur] + 1) % (LMAX + 1);
            else if (d && !u) m_let[m_cur] = (m_let[m_cur] + LMAX) % (LMAX + 1);
        end else if (m_mode == 1) begin
            if (rd) begin
                m_cnt++;
                m_cur = 0;
`ifndef RETAIN_GUESS_EN
                for (int i = 0; i < 5; i++) m_let[i] = 0;
`endif
                m_mode = (m_cnt == MAXG) ? 2 : 0;
            end
        end
    endtask

    task automatic cyc(input logic u, d, l, r, e, w, rd);
        btn_up = u; btn_down = d; btn_left = l; btn_right = r;
        btn_enter = e; game_won = w; guess_ready = rd;
        @(posedge logicclk);
        m_step(u, d, l, r, e, w, rd);
        #1;
        btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0;
        btn_enter = 0; game_won = 0; guess_ready = 0;
    endtask

    task automatic do_reset();
        clr = 1'b1;
        @(posedge logicclk);
        #1;
        clr = 1'b0;
        m_reset();
    endtask

    task automatic test_reset();
        do_reset();
        tests++; if (guess_word !== 25'd0) begin fails++;
            $display("FAIL reset_word: got %h want 0", guess_word); end
        tests++; if (cursor !== 3'd0) begin fails++;
            $display("FAIL reset_cursor: got %0d want 0", cursor); end
        tests++; if (guess_valid !== 1'b0) begin fails++;
            $display("FAIL reset_valid: got %b want 0", guess_valid); end
        tests++; if (guess_count !== 3'd0) begin fails++;
            $display("FAIL reset_count: got %0d want 0", guess_count); end
        tests++; if (locked !== 1'b0) begin fails++;
            $display("FAIL reset_locked: got %b want 0", locked); end
    endtask

    task automatic test_wrap();
        do_reset();
        cyc(0, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0, 0);
        tests++; if (guess_word !== 25'h0000019) begin fails++;
            $display("FAIL wrap_word: got %h want 0000019", guess_word); end
        tests++; if (cursor !== 3'd0) begin fails++;
            $display("FAIL wrap_cursor: got %0d want 0", cursor); end
        cyc(1, 0, 0, 0, 0, 0, 0);
        tests++; if (guess_word !== 25'd0) begin fails++;
            $display("FAIL wrap_up: got %h want 0", guess_word); end
    endtask

    task automatic test_entry();
        do_reset();
        repeat (4) cyc(0, 0, 0, 1, 0, 0, 0);
        repeat (3) cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 0);
        tests++; if (cursor !== 3'd4) begin fails++;
            $display("FAIL entry_cursor: got %0d want 4", cursor); end
        tests++; if (guess_word !== 25'h0300000) begin fails++;
            $display("FAIL entry_word: got %h want 0300000", guess_word); end
    endtask

    // continues from the state left by test_entry
    task automatic test_submit();
        logic [24:0] held;
        held = guess_word;
        cyc(0, 0, 0, 0, 1, 0, 0);
        for (int k = 0; k < 4; k++) begin
            tests++; if (guess_valid !== 1'b1) begin fails++;
                $display("FAIL submit_valid%0d: got %b want 1", k, guess_valid); end
            tests++; if (guess_word !== held) begin fails++;
                $display("FAIL submit_frozen%0d: got %h want %h", k, guess_word, held); end
            if (k < 3) cyc(1, 0, 0, 0, 0, 0, 0);
        end
        cyc(0, 0, 0, 0, 0, 0, 1);
        tests++; if (guess_valid !== 1'b0) begin fails++;
            $display("FAIL submit_drop: got %b want 0", guess_valid); end
        tests++; if (guess_count !== 3'd1) begin fails++;
            $display("FAIL submit_count: got %0d want 1", guess_count); end
        tests++; if (cursor !== 3'd0) begin fails++;
            $display("FAIL submit_cursor: got %0d want 0", cursor); end
`ifdef RETAIN_GUESS_EN
        tests++; if (guess_word !== held) begin fails++;
            $display("FAIL submit_word: got %h want %h", guess_word, held); end
`else
        tests++; if (guess_word !== 25'd0) begin fails++;
            $display("FAIL submit_word: got %h want 0", guess_word); end
`endif
    endtask

    task automatic test_simultaneous();
        do_reset();
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 0);
        tests++; if (guess_word !== 25'd1) begin fails++;
            $display("FAIL simul_updown: got %h want 1", guess_word); end
        cyc(1, 0, 1, 1, 0, 0, 0);
        tests++; if (guess_word !== 25'd1 || cursor !== 3'd0) begin fails++;
            $display("FAIL simul_lr: got %h/%0d want 1/0", guess_word, cursor); end
        cyc(0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 1, 0, 1);
        tests++; if (guess_valid !== 1'b1 || cursor !== 3'd1) begin fails++;
            $display("FAIL simul_enter_right: got v%b c%0d want v1 c1",
                     guess_valid, cursor); end
        tests++; if (guess_count !== 3'd0) begin fails++;
            $display("FAIL simul_ready_entry: got %0d want 0", guess_count); end
        cyc(0, 0, 0, 0, 0, 1, 1);
        tests++; if (locked !== 1'b0 || guess_count !== 3'd1) begin fails++;
            $display("FAIL won_in_submit: got l%b c%0d want l0 c1",
                     locked, guess_count); end
    endtask

    task automatic test_limit();
        do_reset();
        for (int g = 1; g <= MAXG; g++) begin
            cyc(0, 0, 0, 0, 1, 0, 0);
            cyc(0, 0, 0, 0, 0, 0, 1);
            tests++; if (guess_count !== 3'(g)) begin fails++;
                $display("FAIL limit_count%0d: got %0d want %0d", g, guess_count, g); end
        end
        tests++; if (locked !== 1'b1) begin fails++;
            $display("FAIL limit_locked: got %b want 1", locked); end
        for (int k = 0; k < 3; k++) begin
            cyc(1, 0, 0, 1, 1, 0, 1);
            tests++; if (guess_valid !== 1'b0 || guess_count !== 3'(MAXG)) begin
                fails++;
                $display("FAIL limit_hold%0d: got v%b c%0d want v0 c%0d",
                         k, guess_valid, guess_count, MAXG); end
        end
    endtask

    task automatic test_won();
        do_reset();
        cyc(0, 0, 0, 0, 0, 1, 0);
        tests++; if (locked !== 1'b1) begin fails++;
            $display("FAIL won_locked: got %b want 1", locked); end
        do_reset();
        cyc(1, 0, 0, 0, 1, 1, 0);
        tests++; if (locked !== 1'b1 || guess_valid !== 1'b0 || guess_word !== 25'd0)
        begin fails++;
            $display("FAIL won_priority: got l%b v%b w%h want l1 v0 w0",
                     locked, guess_valid, guess_word); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0);
        tests++; if (guess_valid !== 1'b1) begin fails++;
            $display("FAIL midrst_pre: got %b want 1", guess_valid); end
        #3;
        clr = 1'b1;
        #1;
        tests++; if (guess_valid !== 1'b0) begin fails++;
            $display("FAIL midrst_valid: got %b want 0", guess_valid); end
        tests++; if (guess_word !== 25'd0 || cursor !== 3'd0 ||
                     guess_count !== 3'd0 || locked !== 1'b0) begin fails++;
            $display("FAIL midrst_outs: got w%h c%0d n%0d l%b want zeros",
                     guess_word, cursor, guess_count, locked); end
        @(posedge logicclk);
        #1;
        clr = 1'b0;
        m_reset();
    endtask

    task automatic test_random();
        logic u, d, l, r, e, w, rd;
        do_reset();
        for (int n = 0; n < 800; n++) begin
            u  = ($urandom_range(0, 2) == 0);
            d  = ($urandom_range(0, 3) == 0);
            l  = ($urandom_range(0, 4) == 0);
            r  = ($urandom_range(0, 3) == 0);
            e  = ($urandom_range(0, 9) == 0);
            w  = ($urandom_range(0, 119) == 0);
            rd = ($urandom_range(0, 1) == 0);
            cyc(u, d, l, r, e, w, rd);
            tests++; if (guess_word !== m_word()) begin fails++;
                $display("FAIL rnd_word@%0d: got %h want %h", n, guess_word, m_word()); end
            tests++; if (cursor !== 3'(m_cur)) begin fails++;
                $display("FAIL rnd_cursor@%0d: got %0d want %0d", n, cursor, m_cur); end
            tests++; if (guess_valid !== (m_mode == 1)) begin fails++;
                $display("FAIL rnd_valid@%0d: got %b want %b", n, guess_valid, m_mode == 1); end
            tests++; if (guess_count !== 3'(m_cnt)) begin fails++;
                $display("FAIL rnd_count@%0d: got %0d want %0d", n, guess_count, m_cnt); end
            tests++; if (locked !== (m_mode == 2)) begin fails++;
                $display("FAIL rnd_locked@%0d: got %b want %b", n, locked, m_mode == 2); end
            if (m_mode == 2 && $urandom_range(0, 5) == 0) do_reset();
        end
    endtask

    initial begin
        m_reset();
        test_reset();
        test_wrap();
        test_entry();
        test_submit();
        test_simultaneous();
        test_limit();
        test_won();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/guess_entry_ctrl.md
Name: guess_entry_ctrl

Overview:
- Consumes the single-cycle pulses from the five button debouncers (up, down, left, right, enter).
- Builds a 5-letter guess buffer: up/down cycle the letter under the cursor, left/right move the cursor, enter submits.
- Hands the frozen guess to the downstream word checker over a valid/ready handshake.
- Counts submitted guesses and locks out input when the game is won or the guess limit is reached.

Parameters:
- MAX_GUESSES, 6, number of accepted submissions before entering LOCKED (legal range 1..7).
- LETTER_MAX, 25, highest letter code (0 = 'A' .. 25 = 'Z'); letter codes wrap at this value.

Ports:
- logicclk  input  1  system clock; all logic rising-edge.
- clr  input  1  reset, asynchronous, active-high.
- btn_up  input  1  debounced 1-cycle pulse: increment the letter at the cursor.
- btn_down  input  1  debounced 1-cycle pulse: decrement the letter at the cursor.
- btn_left  input  1  debounced 1-cycle pulse: move the cursor toward slot 0.
- btn_right  input  1  debounced 1-cycle pulse: move the cursor toward slot 4.
- btn_enter  input  1  debounced 1-cycle pulse: submit the guess.
- game_won  input  1  level or pulse from the checker: the game has been won.
- guess_ready  input  1  checker accepts the guess in the current cycle.
- guess_word  output  25  5 letters × 5 bits; slot 0 in [4:0], slot 4 in [24:20].
- cursor  output  3  active slot, 0..4.
- guess_valid  output  1  guess_word is stable and offered to the checker.
- guess_count  output  3  number of accepted submissions.
- locked  output  1  high in LOCKED state.

Behaviour:
- Reset (clr high, async):
  - State goes to EDIT.
  - guess_word = 0 (all 'A'), cursor = 0, guess_valid = 0, guess_count = 0, locked = 0.
- All outputs are registered. Every effect appears on the clock edge after the pulse cycle (1-cycle latency).
- EDIT state, pulses evaluated each cycle with this priority: enter > horizontal > vertical. Only one action per cycle; lower-priority pulses in the same cycle are dropped.
  - enter: go to SUBMIT; guess_valid = 1 on the next cycle.
  - left and right together: no cursor change, and vertical pulses are still dropped for that cycle.
  - left only: cursor - 1, saturating at 0.
  - right only: cursor + 1, saturating at 4.
  - up and down together: no change.
  - up only: letter[cursor] + 1; LETTER_MAX wraps to 0.
  - down only: letter[cursor] - 1; 0 wraps to LETTER_MAX.
  - game_won high: go to LOCKED. This takes precedence over every button in the same cycle.
- SUBMIT state:
  - guess_valid held high; guess_word and cursor frozen; all button pulses ignored (not queued).
  - game_won is ignored in this state.
  - On guess_valid && guess_ready:
    - guess_valid = 0 next cycle; guess_count + 1.
    - Buffer handling per the optional feature; cursor = 0.
    - If the new count equals MAX_GUESSES, go to LOCKED; otherwise return to EDIT.
  - guess_ready high in the same cycle SUBMIT is entered (guess_valid still 0) does not count as a handshake.
- LOCKED state:
  - locked = 1, guess_valid = 0; all inputs ignored; guess_word and guess_count hold.
  - Exits only through clr.
- guess_count never exceeds MAX_GUESSES. It does not wrap.
- clr asserted in any state, including mid-handshake, aborts the handshake immediately. guess_valid drops asynchronously with clr.
- State encoding: 2-bit, EDIT = 0, SUBMIT = 1, LOCKED = 2. Code 3 is illegal and recovers to EDIT on the next edge.

Optional Feature:
- Macro: RETAIN_GUESS_EN.
- Defined: after an accepted submission, guess_word keeps the submitted letters as the starting point for the next guess.
- Undefined: after an accepted submission, guess_word is cleared to 0 (all 'A').
- Cursor returns to 0 in both cases.

Test Plan:
- Wrap and saturation:
  - Stimulus: after reset, pulse down once, then left once.
  - Required: letter[0] = 25, cursor = 0, guess_word = 25'h0000019.
- Cursor and letter entry:
  - Stimulus: right ×4, up ×3, then right ×1.
  - Required: cursor = 4 (saturated), guess_word[24:20] = 3, other slots 0.
- Submit handshake:
  - Stimulus: enter; hold guess_ready = 0 for 3 cycles while pulsing up; then guess_ready = 1 for 1 cycle.
  - Required: guess_valid high for 4 cycles; guess_word unchanged throughout; then guess_count = 1, cursor = 0.
  - guess_word = 0 with RETAIN_GUESS_EN undefined; previous word with it defined.
- Simultaneous pulses:
  - Stimulus: up+down in the same cycle; then enter+right in the same cycle.
  - Required: the first leaves the letter unchanged; the second gives SUBMIT with cursor unchanged.
- Guess limit:
  - Stimulus: 6 enter/ready handshakes.
  - Required: guess_count = 6, locked = 1; further enter pulses produce no guess_valid.
- Win and mid-handshake reset:
  - Stimulus: game_won in EDIT.
  - Required: locked = 1 next cycle.
  - Stimulus: in SUBMIT, assert clr between clock edges.
  - Required: guess_valid = 0 immediately; all outputs at reset values.
